// File: rtl/aftab_divider.sv
// rtl/aftab_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module aftab_divider #(
    parameter int size = 32
) (
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    input  logic            start,
    input  logic            clk,
    input  logic            rst,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            ready,
    output logic            dividedByZero
);

    localparam int CW = $clog2(size + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [size-1:0] r_p;
    logic [size-1:0] r_q;
    logic [size-1:0] r_divisor;
    logic [CW-1:0]   r_count;

    logic [size:0]   w_shift;
    logic            w_ge;
    logic [size-1:0] w_diff;
    logic [size-1:0] w_p_next;
    logic [size-1:0] w_q_next;

    // Trial uses the full partial remainder so large divisors cannot lose the MSB.
    always_comb begin
        w_shift  = {r_p, r_q[size-1]};
        w_ge     = (w_shift >= {1'b0, r_divisor});
        w_diff   = w_shift[size-1:0] - r_divisor;
        w_p_next = w_ge ? w_diff : w_shift[size-1:0];
        w_q_next = {r_q[size-2:0], w_ge};
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (divisor == '0) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (r_count == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_p           <= '0;
            r_q           <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            quotient      <= '0;
            remainder     <= '0;
            ready         <= 1'b0;
            dividedByZero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            ready   <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_divisor     <= divisor;
                        r_count       <= CW'(size - 1);
                        dividedByZero <= 1'b0;
                        if (divisor == '0) begin
                            quotient      <= '1;
                            remainder     <= dividend;
                            dividedByZero <= 1'b1;
                        end else begin
                            r_p <= '0;
                            r_q <= dividend;
                        end
                    end
                end
                DIVIDE: begin
                    r_p <= w_p_next;
                    r_q <= w_q_next;
                    if (r_count == '0) begin
                        quotient  <= w_q_next;
                        remainder <= w_p_next;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_divider.sv
// tb/tb_aftab_divider.sv - scoreboard bench for aftab_divider at size 33
module tb_aftab_divider;

    localparam int SZ = 33;
    localparam logic [SZ-1:0] MAXV = {SZ{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SZ-1:0] dividend = '0;
    logic [SZ-1:0] divisor = '0;
    logic          start = 1'b0;
    logic [SZ-1:0] quotient;
    logic [SZ-1:0] remainder;
    logic          ready;
    logic          dividedByZero;

    aftab_divider #(.size(SZ)) dut (
        .dividend     (dividend),
        .divisor      (divisor),
        .start        (start),
        .clk          (clk),
        .rst          (rst),
        .quotient     (quotient),
        .remainder    (remainder),
        .ready        (ready),
        .dividedByZero(dividedByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SZ-1:0] q;
        logic [SZ-1:0] r;
        logic          dbz;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (ready) begin
            exp_t e;
            n_ready++;
            if (sb.size() == 0) begin
                check("spurious_ready", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", dividedByZero, e.dbz);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic [SZ-1:0] a, input logic [SZ-1:0] b, input int hold);
        exp_t e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (b == '0) begin
            e.q   = MAXV;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            e.q   = SZ'(64'(a) / 64'(b));
            e.r   = SZ'(64'(a) % 64'(b));
            e.dbz = 1'b0;
            e.lat = SZ + 1;
        end
        sb.push_back(e);
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_ready", ready, 0);
        check("rst_dbz", dividedByZero, 0);
        rst = 1'b1;

        p0 = n_ready;
        issue(33'd120, 33'd7, 2);
        drain();
        check("single_pulse_hold2", n_ready - p0, 1);

        issue(33'd5, 33'd9, 1);
        drain();
        issue(MAXV, 33'd1, 1);
        drain();
        issue(MAXV, MAXV, 1);
        drain();
        issue(33'd100, 33'd0, 1);
        drain();
        check("dbz_hold", dividedByZero, 1);
        issue(33'd100, 33'd10, 1);
        drain();
        issue(33'h1_2345_6789, 33'h0_0001_0003, 1);
        drain();

        p0 = n_ready;
        issue(33'd120, 33'd7, 1);
        repeat (10) @(negedge clk);
        dividend = 33'd9;
        divisor  = 33'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("midrun_one_pulse", n_ready - p0, 1);

        p0 = n_ready;
        issue(33'd120, 33'd7, 1);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_ready", ready, 0);
        check("abort_dbz", dividedByZero, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_pulse", n_ready - p0, 0);
        issue(33'd200, 33'd9, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
